// File: rtl/cache_bus_arbiter.sv
// Shares one memory bus between the I-cache (F) and D-cache (M) controllers; grant one cycle after request, held for the whole burst.
// Owner's HReady is forwarded combinationally; the non-owner simply waits with BusReady low; an IDLE turnaround sits between grants.
module cache_bus_arbiter #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32,
  parameter int BEATW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             HRequestF,
  input  logic [ADDRW-1:0] HAddrF,
  input  logic             HRequestM,
  input  logic             HWriteM,
  input  logic [ADDRW-1:0] HAddrM,
  input  logic [DATAW-1:0] HWDataM,
  input  logic             HReady,
  output logic             HRequest,
  output logic             HWrite,
  output logic [ADDRW-1:0] HAddr,
  output logic [DATAW-1:0] HWData,
  output logic             BusReadyF,
  output logic             BusReadyM,
  output logic             GrantF,
  output logic             GrantM,
  output logic [BEATW-1:0] BeatCnt,
  output logic             StrayReady
);

  typedef enum logic [1:0] {IDLE, OWN_F, OWN_M} state_t;

  state_t state;
  logic   last_m;
  logic   stray;

  assign BusReadyF = GrantF & HRequestF & HReady;
  assign BusReadyM = GrantM & HRequestM & HReady;
  // Any HReady not handed to a requesting owner is stray, including the drop cycle.
  assign stray     = HReady & ~(BusReadyF | BusReadyM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_m     <= 1'b0;
      GrantF     <= 1'b0;
      GrantM     <= 1'b0;
      BeatCnt    <= '0;
      StrayReady <= 1'b0;
    end else begin
      if (stray) StrayReady <= 1'b1;
      case (state)
        IDLE: begin
          BeatCnt <= '0;
          // Round-robin on a tie: whoever did not win last time goes first.
          if (HRequestM && (!HRequestF || !last_m)) begin
            state  <= OWN_M;
            GrantM <= 1'b1;
            last_m <= 1'b1;
          end else if (HRequestF) begin
            state  <= OWN_F;
            GrantF <= 1'b1;
            last_m <= 1'b0;
          end
        end
        OWN_F: begin
          if (!HRequestF) begin
            state   <= IDLE;
            GrantF  <= 1'b0;
            BeatCnt <= '0;
          end else if (BusReadyF && BeatCnt != {BEATW{1'b1}}) begin
            BeatCnt <= BeatCnt + 1'b1;
          end
        end
        OWN_M: begin
          if (!HRequestM) begin
            state   <= IDLE;
            GrantM  <= 1'b0;
            BeatCnt <= '0;
          end else if (BusReadyM && BeatCnt != {BEATW{1'b1}}) begin
            BeatCnt <= BeatCnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          GrantF  <= 1'b0;
          GrantM  <= 1'b0;
          BeatCnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    HRequest = 1'b0;
    HWrite   = 1'b0;
    HAddr    = '0;
    HWData   = '0;
    case (state)
      OWN_M: begin
        HRequest = HRequestM;
        HWrite   = HWriteM;
        HAddr    = HAddrM;
        HWData   = HWDataM;
      end
      OWN_F: begin
        HRequest = HRequestF;
        HAddr    = HAddrF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: an owner/last-winner model checked every cycle, plus literal spot checks.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        HRequestF = 1'b0;
  logic [31:0] HAddrF = '0;
  logic        HRequestM = 1'b0;
  logic        HWriteM = 1'b0;
  logic [31:0] HAddrM = '0;
  logic [31:0] HWDataM = '0;
  logic        HReady = 1'b0;
  logic        HRequest, HWrite, BusReadyF, BusReadyM, GrantF, GrantM, StrayReady;
  logic [31:0] HAddr, HWData;
  logic [2:0]  BeatCnt;

  int total = 0;
  int bad = 0;

  cache_bus_arbiter #(.ADDRW(32), .DATAW(32), .BEATW(3)) dut (
    .clk(clk), .reset(reset),
    .HRequestF(HRequestF), .HAddrF(HAddrF),
    .HRequestM(HRequestM), .HWriteM(HWriteM), .HAddrM(HAddrM), .HWDataM(HWDataM),
    .HReady(HReady),
    .HRequest(HRequest), .HWrite(HWrite), .HAddr(HAddr), .HWData(HWData),
    .BusReadyF(BusReadyF), .BusReadyM(BusReadyM),
    .GrantF(GrantF), .GrantM(GrantM), .BeatCnt(BeatCnt), .StrayReady(StrayReady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 F, 2 M), who won last, words done, sticky stray.
  int owner = 0;
  bit last_was_m = 1'b0;
  int words = 0;
  bit sticky = 1'b0;
  bit fwd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      owner = 0; last_was_m = 1'b0; words = 0; sticky = 1'b0;
    end else begin
      fwd = HReady && ((owner == 1 && HRequestF) || (owner == 2 && HRequestM));
      if (HReady && !fwd) sticky = 1'b1;
      if (owner == 0) begin
        if (HRequestF && HRequestM) owner = last_was_m ? 1 : 2;
        else if (HRequestM) owner = 2;
        else if (HRequestF) owner = 1;
        if (owner != 0) last_was_m = (owner == 2);
        words = 0;
      end else if ((owner == 1 && !HRequestF) || (owner == 2 && !HRequestM)) begin
        owner = 0;
        words = 0;
      end else if (fwd && words < 7) begin
        words++;
      end
    end
  end

  always @(negedge clk) begin
    chk("HRequest", 32'(HRequest),
        32'(owner == 2 ? HRequestM : owner == 1 ? HRequestF : 1'b0));
    chk("HWrite", 32'(HWrite), 32'(owner == 2 ? HWriteM : 1'b0));
    chk("HAddr", HAddr, owner == 2 ? HAddrM : owner == 1 ? HAddrF : 32'h0);
    chk("HWData", HWData, owner == 2 ? HWDataM : 32'h0);
    chk("BusReadyF", 32'(BusReadyF), 32'(owner == 1 && HRequestF && HReady));
    chk("BusReadyM", 32'(BusReadyM), 32'(owner == 2 && HRequestM && HReady));
    chk("GrantF", 32'(GrantF), 32'(owner == 1));
    chk("GrantM", 32'(GrantM), 32'(owner == 2));
    chk("BeatCnt", 32'(BeatCnt), 32'(words));
    chk("StrayReady", 32'(StrayReady), 32'(sticky));
  end

  task automatic cyc(input logic rf, input logic [31:0] af, input logic rm, input logic wm,
                     input logic [31:0] am, input logic [31:0] dm, input logic rdy);
    @(posedge clk); #1;
    HRequestF = rf; HAddrF = af; HRequestM = rm; HWriteM = wm;
    HAddrM = am; HWDataM = dm; HReady = rdy;
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1;
    reset = 1'b1;
    HRequestF = 1'b0; HAddrF = '0; HRequestM = 1'b0; HWriteM = 1'b0;
    HAddrM = '0; HWDataM = '0; HReady = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
  endtask

  localparam logic [31:0] AF = 32'h0000_1000;
  localparam logic [31:0] AM = 32'h8000_0040;

  initial begin
    logic wr;
    logic [31:0] d;
    // Reset state
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_GrantM", 32'(GrantM), 0);
    chk("lit_rst_HRequest", 32'(HRequest), 0);
    chk("lit_rst_BeatCnt", 32'(BeatCnt), 0);
    chk("lit_rst_Stray", 32'(StrayReady), 0);
    @(negedge clk); reset = 1'b0;

    // Lone clean D miss
    cyc(0, 0, 1, 0, AM, 0, 0);
    chk("lit_t1_c0_GrantM", 32'(GrantM), 0);
    cyc(0, 0, 1, 0, AM, 0, 0);
    chk("lit_t1_c1_GrantM", 32'(GrantM), 1);
    chk("lit_t1_c1_HAddr", HAddr, AM);
    for (int c = 2; c <= 5; c++) begin
      cyc(0, 0, 1, 0, AM, 0, 1);
      chk("lit_t1_BusReadyM", 32'(BusReadyM), 1);
      chk("lit_t1_BusReadyF", 32'(BusReadyF), 0);
    end
    cyc(0, 0, 1, 0, AM, 0, 0);
    chk("lit_t1_BeatCnt", 32'(BeatCnt), 4);
    cyc(0, 0, 0, 0, AM, 0, 0);
    chk("lit_t1_c7_GrantM", 32'(GrantM), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_t1_c8_GrantM", 32'(GrantM), 0);
    chk("lit_t1_c8_BeatCnt", 32'(BeatCnt), 0);

    // Write-back then refill in one grant
    cyc(0, 0, 1, 1, AM, 32'hD000_0000, 0);
    cyc(0, 0, 1, 1, AM, 32'hD000_0000, 0);
    for (int b = 0; b < 8; b++) begin
      wr = (b < 4);
      d = 32'hD000_0000 + b;
      cyc(0, 0, 1, wr, AM + b * 4, d, 1);
      chk("lit_t2_HWrite", 32'(HWrite), 32'(wr));
      if (wr) chk("lit_t2_HWData", HWData, d);
    end
    cyc(0, 0, 1, 0, AM, 0, 0);
    chk("lit_t2_BeatCnt_sat", 32'(BeatCnt), 7);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Simultaneous requests after reset: M first, turnaround, then F
    rst_pulse();
    cyc(1, AF, 1, 0, AM, 0, 0);
    cyc(1, AF, 1, 0, AM, 0, 0);
    chk("lit_t3_GrantM", 32'(GrantM), 1);
    chk("lit_t3_GrantF", 32'(GrantF), 0);
    cyc(1, AF, 1, 0, AM, 0, 1);
    chk("lit_t3_BusReadyF", 32'(BusReadyF), 0);
    cyc(1, AF, 0, 0, AM, 0, 0);
    cyc(1, AF, 0, 0, 0, 0, 0);
    chk("lit_t3_turn_GrantF", 32'(GrantF), 0);
    chk("lit_t3_turn_GrantM", 32'(GrantM), 0);
    cyc(1, AF, 0, 1, AM, 32'hFFFF_FFFF, 0);
    chk("lit_t3_GrantF_on", 32'(GrantF), 1);
    chk("lit_t3_HAddrF", HAddr, AF);
    chk("lit_t3_HWrite0", 32'(HWrite), 0);
    cyc(0, AF, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Starvation: M keeps re-requesting, grants must alternate M, F, M, F
    for (int r = 0; r < 4; r++) begin
      cyc(1, AF, 1, 0, AM, 0, 0);
      cyc(1, AF, 1, 0, AM, 0, 0);
      chk("lit_t4_GrantM", 32'(GrantM), 32'(r % 2 == 0));
      chk("lit_t4_GrantF", 32'(GrantF), 32'(r % 2 == 1));
      cyc(1, AF, 1, 0, AM, 0, 1);
      if (r % 2 == 0) cyc(1, AF, 0, 0, AM, 0, 0);
      else            cyc(0, AF, 1, 0, AM, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Stray ready in IDLE
    rst_pulse();
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_t5_Stray_before", 32'(StrayReady), 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit_t5_BusReadyM", 32'(BusReadyM), 0);
    chk("lit_t5_BusReadyF", 32'(BusReadyF), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_t5_Stray_set", 32'(StrayReady), 1);
    cyc(0, AF, 1, 0, AM, 0, 0);
    cyc(0, AF, 1, 0, AM, 0, 0);
    chk("lit_t5_Stray_sticky", 32'(StrayReady), 1);

    // Owner drops request in the same cycle HReady arrives
    rst_pulse();
    chk("lit_e_Stray_clr", 32'(StrayReady), 0);
    cyc(0, 0, 1, 0, AM, 0, 0);
    cyc(0, 0, 1, 0, AM, 0, 0);
    cyc(0, 0, 0, 0, AM, 0, 1);
    chk("lit_e_BusReadyM", 32'(BusReadyM), 0);
    chk("lit_e_GrantM", 32'(GrantM), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_e_idle", 32'(GrantM), 0);
    chk("lit_e_Stray", 32'(StrayReady), 1);

    // Reset mid-burst, then a pending F request
    rst_pulse();
    cyc(1, AF, 1, 0, AM, 0, 0);
    cyc(1, AF, 1, 0, AM, 0, 0);
    cyc(1, AF, 1, 0, AM, 0, 1);
    cyc(1, AF, 1, 0, AM, 0, 1);
    chk("lit_t6_BeatCnt", 32'(BeatCnt), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("lit_t6_GrantM", 32'(GrantM), 0);
    chk("lit_t6_HRequest", 32'(HRequest), 0);
    chk("lit_t6_HAddr", HAddr, 0);
    chk("lit_t6_BusReadyM", 32'(BusReadyM), 0);
    chk("lit_t6_BeatCnt0", 32'(BeatCnt), 0);
    reset = 1'b0; HRequestM = 1'b0; HReady = 1'b0;
    cyc(1, AF, 0, 0, 0, 0, 0);
    chk("lit_t6_GrantF", 32'(GrantF), 1);
    chk("lit_t6_HAddrF", HAddr, AF);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
